rx_serial_7o1_buffer: RTL and testbench

Serial receiver for 7O1 frames (1 start, 7 data LSB-first, odd parity, 1 stop) that assembles a burst of 8 ASCII characters into an on-chip buffer. It is the receiving end of the 8-character ASCII serial link. It consumes the line driven by the ASCII transmitter and presents the 8 characters, plus parity and framing status, to the downstream logic (display and comparison).

---
 rtl/rx_serial_7o1_buffer.sv | 146 ++++++++++++++
 tb/tb_rx_serial_7o1_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7o1_buffer.sv
// 7O1 serial receiver (start, 7 data LSB-first, odd parity, stop) that collects
// a burst of 8 ASCII characters into a 56-bit buffer with parity/framing status.
//
// state        | meaning
// -------------+-------------------------------------------------
// INICIAL      | after reset, waiting for recebe
// ESPERA       | armed, waiting for a start edge on the line
// START        | half-bit wait, then confirm the start bit
// DADOS        | sampling the 7 data bits
// PARIDADE     | sampling the parity bit
// STOP         | sampling the stop bit
// ARMAZENA     | pronto pulse, advance the character index
// AGUARDA_IDLE | bad stop bit, wait for the line to return high
// FINAL        | 8 characters stored, waiting for a new recebe
module rx_serial_7o1_buffer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        recebe,
    input  logic        entrada_serial,
    output logic [55:0] dados_ascii,
    output logic        pronto,
    output logic        fim_recepcao,
    output logic        erro_paridade,
    output logic        erro_stop,
    output logic [3:0]  db_estado
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA       = 4'd1,
        START        = 4'd2,
        DADOS        = 4'd3,
        PARIDADE     = 4'd4,
        STOP         = 4'd5,
        ARMAZENA     = 4'd6,
        AGUARDA_IDLE = 4'd7,
        FINAL        = 4'd15
    } state_t;

    state_t          state, state_next;
    logic            sync_a, line;
    logic [TW-1:0]   timer;
    logic            tick;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic            par_bad, stop_bad;
    logic [2:0]      index;
    logic            arm;

    assign tick = (timer == '0);
    assign arm  = recebe && ((state == INICIAL) || (state == FINAL));

    always_ff @(posedge clock) begin
        if (reset) state <= INICIAL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pronto     = 1'b0;
        db_estado  = state;
        case (state)
            INICIAL:      if (recebe) state_next = ESPERA;
            ESPERA:       if (!line) state_next = START;
            START:        if (tick) state_next = line ? ESPERA : DADOS;
            DADOS:        if (tick && (bit_cnt == 3'd6)) state_next = PARIDADE;
            PARIDADE:     if (tick) state_next = STOP;
            STOP:         if (tick) state_next = ARMAZENA;
            ARMAZENA: begin
                pronto = 1'b1;
                if (index == 3'd7)  state_next = FINAL;
                else if (stop_bad)  state_next = AGUARDA_IDLE;
                else                state_next = ESPERA;
            end
            AGUARDA_IDLE: if (line) state_next = ESPERA;
            FINAL:        if (recebe) state_next = ESPERA;
            default:      state_next = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a        <= 1'b1;
            line          <= 1'b1;
            timer         <= '0;
            bit_cnt       <= 3'd0;
            shift         <= 7'd0;
            par_bad       <= 1'b0;
            stop_bad      <= 1'b0;
            index         <= 3'd0;
            dados_ascii   <= 56'd0;
            fim_recepcao  <= 1'b0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
        end else begin
            sync_a <= entrada_serial;
            line   <= sync_a;

            case (state)
                ESPERA: if (!line) begin
                    timer   <= HALF_LOAD;
                    bit_cnt <= 3'd0;
                end
                START, DADOS, PARIDADE, STOP: timer <= tick ? BIT_LOAD : timer - TW'(1);
                default: ;
            endcase

            if (arm) begin
                index         <= 3'd0;
                dados_ascii   <= 56'd0;
                erro_paridade <= 1'b0;
                erro_stop     <= 1'b0;
                fim_recepcao  <= 1'b0;
            end

            if ((state == DADOS) && tick) begin
                shift   <= {line, shift[6:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if ((state == PARIDADE) && tick)
                par_bad <= ~^{shift, line};

            // Commit slot and flags on the stop sample so they are already valid while pronto is high.
            if ((state == STOP) && tick) begin
                stop_bad      <= ~line;
                erro_paridade <= erro_paridade | par_bad;
                erro_stop     <= erro_stop | ~line;
                for (int i = 0; i < 8; i++)
                    if (index == 3'(i)) dados_ascii[i*7 +: 7] <= shift;
            end

            if (state == ARMAZENA) begin
                index <= index + 3'd1;
                if (index == 3'd7) fim_recepcao <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_serial_7o1_buffer.sv
// Bench for rx_serial_7o1_buffer: table bursts, hand-written corner cases and
// random bursts checked against a character-level scoreboard model.
module tb_rx_serial_7o1_buffer;

    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        recebe = 1'b0;
    logic        entrada_serial = 1'b1;
    logic [55:0] dados_ascii;
    logic        pronto, fim_recepcao, erro_paridade, erro_stop;
    logic [3:0]  db_estado;

    rx_serial_7o1_buffer #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .recebe(recebe), .entrada_serial(entrada_serial),
        .dados_ascii(dados_ascii), .pronto(pronto), .fim_recepcao(fim_recepcao),
        .erro_paridade(erro_paridade), .erro_stop(erro_stop), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [55:0] d;
        logic        pe;
        logic        se;
        logic        fim;
    } snap_t;

    typedef struct {
        logic [6:0] ch;
        logic       flip;
        logic       exp_pe;
        logic       rec_pulse;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    snap_t got_q[$];
    snap_t exp_q[$];
    vec_t  tbl[16];

    logic [6:0] m_slot[8];
    int         m_idx;
    logic       m_pe, m_se;

    always @(negedge clock)
        if (pronto) got_q.push_back({dados_ascii, erro_paridade, erro_stop, fim_recepcao});

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic model_arm();
        for (int i = 0; i < 8; i++) m_slot[i] = 7'd0;
        m_idx = 0;
        m_pe  = 1'b0;
        m_se  = 1'b0;
    endtask

    task automatic model_char(input logic [6:0] ch, input logic p, input logic stop);
        logic [55:0] d;
        if ((($countones(ch) + int'(p)) % 2) == 0) m_pe = 1'b1;
        if (!stop) m_se = 1'b1;
        m_slot[m_idx] = ch;
        m_idx++;
        for (int i = 0; i < 8; i++) d[i*7 +: 7] = m_slot[i];
        exp_q.push_back({d, m_pe, m_se, 1'b0});
    endtask

    task automatic send_frame(input logic [6:0] ch, input logic p, input logic stop,
                              input int extra_low, input int gap);
        logic [9:0] fr;
        fr = {stop, p, ch, 1'b0};
        for (int i = 0; i < 10; i++) begin
            entrada_serial = fr[i];
            repeat (CPB) @(negedge clock);
        end
        if (extra_low > 0) begin
            entrada_serial = 1'b0;
            repeat (extra_low) @(negedge clock);
        end
        entrada_serial = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_char(input logic [6:0] ch, input logic flip, input logic stop,
                             input int extra_low, input int gap);
        logic p;
        p = ~(^ch) ^ flip;
        model_char(ch, p, stop);
        send_frame(ch, p, stop, extra_low, gap);
    endtask

    task automatic arm(input string nm);
        recebe = 1'b1;
        @(negedge clock);
        recebe = 1'b0;
        check({nm, "_arm_dados"}, 64'(dados_ascii), 64'd0);
        check({nm, "_arm_flags"}, {62'd0, erro_paridade, erro_stop}, 64'd0);
        check({nm, "_arm_fim"}, 64'(fim_recepcao), 64'd0);
        check({nm, "_arm_state"}, 64'(db_estado), 64'd1);
        model_arm();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_q(input string nm);
        snap_t g, e;
        check({nm, "_pronto_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while ((got_q.size() > 0) && (exp_q.size() > 0)) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({nm, "_snap_dados"}, 64'(g.d), 64'(e.d));
            check({nm, "_snap_flags"}, {61'd0, g.pe, g.se, g.fim}, {61'd0, e.pe, e.se, e.fim});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_final(input string nm);
        check({nm, "_fim"}, 64'(fim_recepcao), 64'd1);
        check({nm, "_state_final"}, 64'(db_estado), 64'd15);
    endtask

    task automatic run_table(input int base, input string nm);
        logic [55:0] full;
        snap_t       s;
        arm(nm);
        for (int i = 0; i < 8; i++) begin
            if (tbl[base+i].rec_pulse) begin
                fork
                    send_char(tbl[base+i].ch, tbl[base+i].flip, 1'b1, 0, 0);
                    begin
                        repeat (30) @(negedge clock);
                        recebe = 1'b1;
                        @(negedge clock);
                        recebe = 1'b0;
                    end
                join
            end else begin
                send_char(tbl[base+i].ch, tbl[base+i].flip, 1'b1, 0, 0);
            end
        end
        repeat (20) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            full[i*7 +: 7] = tbl[base+i].ch;
            if (i < got_q.size()) begin
                s = got_q[i];
                check($sformatf("%s_slot%0d", nm, i), 64'(s.d[i*7 +: 7]), 64'(tbl[base+i].ch));
                check($sformatf("%s_pe%0d", nm, i), 64'(s.pe), 64'(tbl[base+i].exp_pe));
            end else begin
                check($sformatf("%s_missing_pronto%0d", nm, i), 64'(got_q.size()), 64'(i + 1));
            end
        end
        check({nm, "_dados_full"}, 64'(dados_ascii), 64'(full));
        check({nm, "_erro_stop"}, 64'(erro_stop), 64'd0);
        compare_q(nm);
        check_final(nm);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] lab[8];
        lab = '{7'h4C, 7'h61, 7'h62, 7'h44, 7'h69, 7'h67, 7'h32, 7'h35};
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{lab[i], 1'b0, 1'b0, 1'b0};
            tbl[8 + i] = '{lab[i], (i == 3), (i >= 3), (i == 5)};
        end

        // reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_state", 64'(db_estado), 64'd0);
        check("rst_dados", 64'(dados_ascii), 64'd0);
        check("rst_outs", {60'd0, pronto, fim_recepcao, erro_paridade, erro_stop}, 64'd0);

        // reset in the middle of a frame, after two stored characters
        arm("midrst");
        send_char(7'h11, 1'b1, 1'b1, 0, 0);
        send_char(7'h22, 1'b0, 1'b1, 0, 6);
        compare_q("midrst");
        entrada_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            entrada_serial = i[0];
            repeat (CPB) @(negedge clock);
        end
        check("midrst_in_dados", 64'(db_estado), 64'd3);
        entrada_serial = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_state", 64'(db_estado), 64'd0);
        check("midrst_dados", 64'(dados_ascii), 64'd0);
        check("midrst_outs", {60'd0, pronto, fim_recepcao, erro_paridade, erro_stop}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        run_table(0, "clean");
        run_table(8, "perr");

        // framing error, stuck-low line, then a glitch between characters
        arm("frame");
        fork
            send_char(7'h5A, 1'b0, 1'b0, 20, 0);
            begin
                repeat (90) @(negedge clock);
                check("frame_aguarda_idle", 64'(db_estado), 64'd7);
            end
        join
        repeat (5) @(negedge clock);
        check("frame_back_espera", 64'(db_estado), 64'd1);
        check("frame_erro_stop", 64'(erro_stop), 64'd1);
        for (int i = 1; i < 8; i++) begin
            send_char(7'(8'h30 + i), 1'b0, 1'b1, 0, 2);
            if (i == 3) begin
                logic saw_start, saw_pronto;
                saw_start  = 1'b0;
                saw_pronto = 1'b0;
                repeat (4) @(negedge clock);
                entrada_serial = 1'b0;
                repeat (2) @(negedge clock);
                entrada_serial = 1'b1;
                repeat (12) begin
                    @(negedge clock);
                    if (db_estado == 4'd2) saw_start = 1'b1;
                    if (pronto) saw_pronto = 1'b1;
                end
                check("glitch_saw_start", 64'(saw_start), 64'd1);
                check("glitch_no_pronto", 64'(saw_pronto), 64'd0);
                check("glitch_espera", 64'(db_estado), 64'd1);
            end
        end
        repeat (20) @(negedge clock);
        compare_q("frame");
        check_final("frame");

        // random bursts against the scoreboard model
        for (int b = 0; b < 3; b++) begin
            arm($sformatf("rnd%0d", b));
            for (int i = 0; i < 8; i++) begin
                logic [6:0] ch;
                logic       flip, stop;
                int         extra, gap;
                ch   = 7'($urandom_range(0, 127));
                flip = ($urandom_range(0, 5) == 0);
                stop = ($urandom_range(0, 7) != 0);
                if (!stop) begin
                    extra = $urandom_range(0, 10);
                    gap   = $urandom_range(4, 8);
                end else begin
                    extra = 0;
                    gap   = $urandom_range(0, 3);
                end
                send_char(ch, flip, stop, extra, gap);
            end
            repeat (20) @(negedge clock);
            compare_q($sformatf("rnd%0d", b));
            check_final($sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
